// File: rtl/recv_ip_frame.sv
// Purpose: Ethernet II + IPv4 (IHL=5) receive parser. Validates the header,
//          publishes its fields and forwards the IP payload as a 32-bit stream.
// Latency: header verdict one cycle after the last header word; payload is a
//          combinational pass-through, so it adds no cycles.
// Backpressure: o_eth_rdy follows i_out_rdy while forwarding payload. It is held
//          low in FLUSH, and forced low while rst is high.
// Ports:  clk/rst; i_my_ip destination filter; i_eth_* input word stream;
//         o_* header fields + o_hdr_vld; o_out_* payload stream with i_out_rdy;
//         o_err/o_err_code error report.
module recv_ip_frame #(
    parameter bit BCAST_EN   = 1'b1,
    parameter bit CHECK_CSUM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_my_ip,
    input  logic [31:0] i_eth_data,
    input  logic        i_eth_sop,
    input  logic        i_eth_eop,
    input  logic        i_eth_vld,
    output logic        o_eth_rdy,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [31:0] o_src_ip,
    output logic [31:0] o_dst_ip,
    output logic [7:0]  o_protocol,
    output logic [15:0] o_pkt_id,
    output logic        o_more_frame,
    output logic [15:0] o_frame_offset,
    output logic [15:0] o_frame_size,
    output logic        o_hdr_vld,
    output logic [31:0] o_out_data,
    output logic        o_out_sop,
    output logic        o_out_eop,
    output logic        o_out_vld,
    output logic [2:0]  o_out_bytes,
    output logic        o_out_err,
    input  logic        i_out_rdy,
    output logic        o_err,
    output logic [2:0]  o_err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_W1, S_W2, S_W3, S_W4, S_W5, S_W6, S_W7, S_W8,
        S_DATA, S_DISCARD, S_FLUSH
    } state_t;

    localparam logic [2:0] ERR_TRUNC   = 3'd6;
    localparam logic [2:0] ERR_RESTART = 3'd7;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic        first_q, first_d;
    logic        err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        hdr_vld_q;

    // Header fields collected while the header words stream in
    logic [47:0] dmac_s_q, smac_s_q;
    logic [15:0] etype_s_q, tlen_s_q, id_s_q;
    logic [7:0]  verihl_s_q, proto_s_q;
    logic        mf_s_q;
    logic [12:0] frag_s_q;
    logic [31:0] sip_s_q;
    logic [19:0] acc_q;

    // Published header fields, updated only when a header is accepted
    logic [47:0] dst_mac_q, src_mac_q;
    logic [31:0] src_ip_q, dst_ip_q;
    logic [7:0]  protocol_q;
    logic [15:0] pkt_id_q, frame_offset_q, frame_size_q;
    logic        more_frame_q;

    logic        eth_rdy, beat, load_w0, hdr_pass;
    logic [19:0] halves, sum20;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic        dst_ok;
    logic [2:0]  chk_code;

    function automatic state_t hdr_next(input state_t s);
        case (s)
            S_W1:    return S_W2;
            S_W2:    return S_W3;
            S_W3:    return S_W4;
            S_W4:    return S_W5;
            S_W5:    return S_W6;
            S_W6:    return S_W7;
            S_W7:    return S_W8;
            default: return S_IDLE;
        endcase
    endfunction

    assign beat      = i_eth_vld & eth_rdy;
    assign o_eth_rdy = eth_rdy & ~rst;

    // Ones-complement header sum: W8's halves are folded in combinationally
    // so the verdict is ready on the W8 beat itself.
    assign halves = {4'd0, i_eth_data[31:16]} + {4'd0, i_eth_data[15:0]};
    assign sum20  = acc_q + halves;
    assign fold1  = {1'b0, sum20[15:0]} + {13'd0, sum20[19:16]};
    assign fold2  = fold1[15:0] + {15'd0, fold1[16]};
    assign dst_ok = (i_eth_data == i_my_ip) || (BCAST_EN && (i_eth_data == 32'hFFFF_FFFF));

    // Header checks, first failure wins; valid only when i_eth_data is W8
    always_comb begin
        chk_code = 3'd0;
        if (etype_s_q != 16'h0800)
            chk_code = 3'd1;
        else if (verihl_s_q != 8'h45)
            chk_code = 3'd2;
        else if (CHECK_CSUM && (fold2 != 16'hFFFF))
            chk_code = 3'd3;
        else if (!dst_ok)
            chk_code = 3'd4;
        else if (tlen_s_q < 16'd20)
            chk_code = 3'd5;
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        first_d     = first_q;
        eth_rdy     = 1'b0;
        load_w0     = 1'b0;
        hdr_pass    = 1'b0;
        err_d       = 1'b0;
        err_code_d  = 3'd0;
        o_out_data  = 32'd0;
        o_out_vld   = 1'b0;
        o_out_sop   = 1'b0;
        o_out_eop   = 1'b0;
        o_out_bytes = 3'd0;
        o_out_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                eth_rdy = 1'b1;
                if (i_eth_vld && i_eth_sop) begin
                    load_w0 = 1'b1;
                    if (i_eth_eop) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TRUNC;
                    end else begin
                        state_d = S_W1;
                    end
                end
            end
            S_W1, S_W2, S_W3, S_W4, S_W5, S_W6, S_W7, S_W8: begin
                eth_rdy = 1'b1;
                if (i_eth_vld) begin
                    if (i_eth_sop) begin
                        // New frame interrupts the header: restart with this word as W0
                        load_w0    = 1'b1;
                        err_d      = 1'b1;
                        err_code_d = ERR_RESTART;
                        state_d    = i_eth_eop ? S_IDLE : S_W1;
                    end else if (state_q == S_W8) begin
                        if (chk_code != 3'd0) begin
                            err_d      = 1'b1;
                            err_code_d = chk_code;
                            state_d    = i_eth_eop ? S_IDLE : S_DISCARD;
                        end else begin
                            hdr_pass = 1'b1;
                            rem_d    = tlen_s_q - 16'd20;
                            first_d  = 1'b1;
                            if (i_eth_eop)
                                state_d = S_IDLE;
                            else if (tlen_s_q == 16'd20)
                                state_d = S_DISCARD;
                            else
                                state_d = S_DATA;
                        end
                    end else if (i_eth_eop) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TRUNC;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = hdr_next(state_q);
                    end
                end
            end
            S_DATA: begin
                if (i_eth_vld && i_eth_sop) begin
                    // Leave the sop word upstream; it is taken after the flush word
                    state_d    = S_FLUSH;
                    err_d      = 1'b1;
                    err_code_d = ERR_RESTART;
                end else begin
                    eth_rdy    = i_out_rdy;
                    o_out_vld  = i_eth_vld;
                    o_out_data = i_eth_data;
                    o_out_sop  = first_q;
                    if (rem_q <= 16'd4) begin
                        o_out_eop   = 1'b1;
                        o_out_bytes = rem_q[2:0];
                    end else if (i_eth_eop) begin
                        o_out_eop   = 1'b1;
                        o_out_bytes = 3'd4;
                        o_out_err   = 1'b1;
                    end
                    if (i_eth_vld && i_out_rdy) begin
                        first_d = 1'b0;
                        if (rem_q <= 16'd4) begin
                            state_d = i_eth_eop ? S_IDLE : S_DISCARD;
                        end else if (i_eth_eop) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_TRUNC;
                            state_d    = S_IDLE;
                        end else begin
                            rem_d = rem_q - 16'd4;
                        end
                    end
                end
            end
            S_DISCARD: begin
                eth_rdy = 1'b1;
                if (i_eth_vld) begin
                    if (i_eth_sop) begin
                        load_w0 = 1'b1;
                        state_d = i_eth_eop ? S_IDLE : S_W1;
                    end else if (i_eth_eop) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                o_out_vld = 1'b1;
                o_out_eop = 1'b1;
                o_out_err = 1'b1;
                if (i_out_rdy)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rem_q      <= 16'd0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
            hdr_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            hdr_vld_q  <= hdr_pass;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmac_s_q   <= 48'd0;
            smac_s_q   <= 48'd0;
            etype_s_q  <= 16'd0;
            verihl_s_q <= 8'd0;
            tlen_s_q   <= 16'd0;
            id_s_q     <= 16'd0;
            mf_s_q     <= 1'b0;
            frag_s_q   <= 13'd0;
            proto_s_q  <= 8'd0;
            sip_s_q    <= 32'd0;
            acc_q      <= 20'd0;
        end else if (beat) begin
            if (load_w0) begin
                dmac_s_q[47:32] <= i_eth_data[15:0];
            end else begin
                case (state_q)
                    S_W1: dmac_s_q[31:0]  <= i_eth_data;
                    S_W2: smac_s_q[47:16] <= i_eth_data;
                    S_W3: begin
                        smac_s_q[15:0] <= i_eth_data[31:16];
                        etype_s_q      <= i_eth_data[15:0];
                    end
                    S_W4: begin
                        verihl_s_q <= i_eth_data[31:24];
                        tlen_s_q   <= i_eth_data[15:0];
                        acc_q      <= halves;
                    end
                    S_W5: begin
                        id_s_q   <= i_eth_data[31:16];
                        mf_s_q   <= i_eth_data[13];
                        frag_s_q <= i_eth_data[12:0];
                        acc_q    <= sum20;
                    end
                    S_W6: begin
                        proto_s_q <= i_eth_data[23:16];
                        acc_q     <= sum20;
                    end
                    S_W7: begin
                        sip_s_q <= i_eth_data;
                        acc_q   <= sum20;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_mac_q      <= 48'd0;
            src_mac_q      <= 48'd0;
            src_ip_q       <= 32'd0;
            dst_ip_q       <= 32'd0;
            protocol_q     <= 8'd0;
            pkt_id_q       <= 16'd0;
            more_frame_q   <= 1'b0;
            frame_offset_q <= 16'd0;
            frame_size_q   <= 16'd0;
        end else if (hdr_pass) begin
            dst_mac_q      <= dmac_s_q;
            src_mac_q      <= smac_s_q;
            src_ip_q       <= sip_s_q;
            dst_ip_q       <= i_eth_data;
            protocol_q     <= proto_s_q;
            pkt_id_q       <= id_s_q;
            more_frame_q   <= mf_s_q;
            frame_offset_q <= {frag_s_q, 3'd0};
            frame_size_q   <= tlen_s_q - 16'd20;
        end
    end

    assign o_dst_mac      = dst_mac_q;
    assign o_src_mac      = src_mac_q;
    assign o_src_ip       = src_ip_q;
    assign o_dst_ip       = dst_ip_q;
    assign o_protocol     = protocol_q;
    assign o_pkt_id       = pkt_id_q;
    assign o_more_frame   = more_frame_q;
    assign o_frame_offset = frame_offset_q;
    assign o_frame_size   = frame_size_q;
    assign o_hdr_vld      = hdr_vld_q;
    assign o_err          = err_q;
    assign o_err_code     = err_code_q;

endmodule

// File: tb/tb_recv_ip_frame.sv
// Purpose: directed bench for recv_ip_frame; a second instance has the
//          checksum check disabled.
// Latency: words driven #1 after posedge, outputs sampled on negedge.
// Backpressure: i_out_rdy is high, or toggles every cycle when tog_en is set.
module tb_recv_ip_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_my_ip;
    logic [31:0] i_eth_data;
    logic        i_eth_sop, i_eth_eop, i_eth_vld;
    logic        o_eth_rdy;
    logic [47:0] o_dst_mac, o_src_mac;
    logic [31:0] o_src_ip, o_dst_ip;
    logic [7:0]  o_protocol;
    logic [15:0] o_pkt_id, o_frame_offset, o_frame_size;
    logic        o_more_frame, o_hdr_vld;
    logic [31:0] o_out_data;
    logic        o_out_sop, o_out_eop, o_out_vld, o_out_err;
    logic [2:0]  o_out_bytes;
    logic        i_out_rdy;
    logic        o_err;
    logic [2:0]  o_err_code;

    logic        nc_eth_rdy;
    logic [47:0] nc_dst_mac, nc_src_mac;
    logic [31:0] nc_src_ip, nc_dst_ip;
    logic [7:0]  nc_protocol;
    logic [15:0] nc_pkt_id, nc_frame_offset, nc_frame_size;
    logic        nc_more_frame, nc_hdr_vld;
    logic [31:0] nc_out_data;
    logic        nc_out_sop, nc_out_eop, nc_out_vld, nc_out_err;
    logic [2:0]  nc_out_bytes;
    logic        nc_err;
    logic [2:0]  nc_err_code;

    logic tog_en = 1'b0;
    logic tog_q  = 1'b0;
    assign i_out_rdy = tog_en ? tog_q : 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tog_q = ~tog_q;
    end

    recv_ip_frame dut (
        .clk(clk), .rst(rst), .i_my_ip(i_my_ip),
        .i_eth_data(i_eth_data), .i_eth_sop(i_eth_sop), .i_eth_eop(i_eth_eop),
        .i_eth_vld(i_eth_vld), .o_eth_rdy(o_eth_rdy),
        .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac),
        .o_src_ip(o_src_ip), .o_dst_ip(o_dst_ip), .o_protocol(o_protocol),
        .o_pkt_id(o_pkt_id), .o_more_frame(o_more_frame),
        .o_frame_offset(o_frame_offset), .o_frame_size(o_frame_size),
        .o_hdr_vld(o_hdr_vld), .o_out_data(o_out_data), .o_out_sop(o_out_sop),
        .o_out_eop(o_out_eop), .o_out_vld(o_out_vld), .o_out_bytes(o_out_bytes),
        .o_out_err(o_out_err), .i_out_rdy(i_out_rdy),
        .o_err(o_err), .o_err_code(o_err_code)
    );

    recv_ip_frame #(.BCAST_EN(1'b1), .CHECK_CSUM(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .i_my_ip(i_my_ip),
        .i_eth_data(i_eth_data), .i_eth_sop(i_eth_sop), .i_eth_eop(i_eth_eop),
        .i_eth_vld(i_eth_vld), .o_eth_rdy(nc_eth_rdy),
        .o_dst_mac(nc_dst_mac), .o_src_mac(nc_src_mac),
        .o_src_ip(nc_src_ip), .o_dst_ip(nc_dst_ip), .o_protocol(nc_protocol),
        .o_pkt_id(nc_pkt_id), .o_more_frame(nc_more_frame),
        .o_frame_offset(nc_frame_offset), .o_frame_size(nc_frame_size),
        .o_hdr_vld(nc_hdr_vld), .o_out_data(nc_out_data), .o_out_sop(nc_out_sop),
        .o_out_eop(nc_out_eop), .o_out_vld(nc_out_vld), .o_out_bytes(nc_out_bytes),
        .o_out_err(nc_out_err), .i_out_rdy(i_out_rdy),
        .o_err(nc_err), .o_err_code(nc_err_code)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [2:0]  b;
        logic        x;
    } ow_t;

    ow_t         oq[$];
    logic [2:0]  ecodes[$];
    int          hdr_n = 0, nc_hdr_n = 0, mir_n = 0, mir_bad = 0;
    int          total = 0, bad = 0;
    logic [31:0] fr[$];

    // Output monitor: records payload transfers, header pulses and error codes
    always @(negedge clk) begin
        if (o_out_vld && i_out_rdy)
            oq.push_back({o_out_data, o_out_sop, o_out_eop, o_out_bytes, o_out_err});
        if (o_hdr_vld) hdr_n++;
        if (nc_hdr_vld) nc_hdr_n++;
        if (o_err) ecodes.push_back(o_err_code);
        if (tog_en && o_out_vld) begin
            mir_n++;
            if (o_eth_rdy !== i_out_rdy) mir_bad++;
        end
    end

    function automatic logic [31:0] pay(input int i);
        return 32'hA0B0_0000 + i;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // W4..W8 follow the reference vector; only dst_ip/csum/length vary
    task automatic build(input logic [31:0] dip, input logic [15:0] csum,
                         input int npay, input int npad);
        fr.delete();
        fr.push_back(32'h0000_0200);
        fr.push_back(32'h0000_0001);
        fr.push_back(32'h0200_0000);
        fr.push_back(32'h0002_0800);
        fr.push_back(32'h4500_0073);
        fr.push_back(32'h0000_4000);
        fr.push_back({16'h4011, csum});
        fr.push_back(32'hC0A8_0001);
        fr.push_back(dip);
        for (int i = 0; i < npay; i++) fr.push_back(pay(i));
        for (int i = 0; i < npad; i++) fr.push_back(32'h0);
    endtask

    task automatic send_word(input logic [31:0] d, input logic s, input logic e);
        logic took;
        int   n;
        i_eth_data = d;
        i_eth_sop  = s;
        i_eth_eop  = e;
        i_eth_vld  = 1'b1;
        took = 1'b0;
        n    = 0;
        while (!took && n < 200) begin
            @(negedge clk);
            took = o_eth_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        i_eth_vld = 1'b0;
        i_eth_sop = 1'b0;
        i_eth_eop = 1'b0;
        if (!took) begin
            total++; bad++;
            $display("FAIL send_word: word %h not accepted after %0d cycles", d, n);
        end
    endtask

    task automatic send_frame(input int n, input bit with_eop);
        for (int i = 0; i < n; i++)
            send_word(fr[i], i == 0, with_eop && (i == n - 1));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        total++; if (o_eth_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy: got %b want 0", o_eth_rdy); end
        total++; if (o_hdr_vld !== 1'b0) begin bad++; $display("FAIL rst_hdr_vld: got %b want 0", o_hdr_vld); end
        total++; if (o_out_vld !== 1'b0) begin bad++; $display("FAIL rst_out_vld: got %b want 0", o_out_vld); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", o_err); end
        total++; if (o_dst_mac !== 48'd0) begin bad++; $display("FAIL rst_dst_mac: got %h want 0", o_dst_mac); end
        total++; if (o_frame_size !== 16'd0) begin bad++; $display("FAIL rst_frame_size: got %h want 0", o_frame_size); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (o_eth_rdy !== 1'b1) begin bad++; $display("FAIL idle_rdy: got %b want 1", o_eth_rdy); end
        tick(1);
    endtask

    task automatic test_valid;
        int h0, q0, e0;
        h0 = hdr_n; q0 = oq.size(); e0 = ecodes.size();
        build(32'hC0A8_00C7, 16'hB861, 24, 2);
        send_frame(fr.size(), 1'b1);
        tick(5);
        total++; if (hdr_n - h0 != 1) begin bad++; $display("FAIL valid_hdr_cnt: got %0d want 1", hdr_n - h0); end
        total++; if (o_protocol !== 8'h11) begin bad++; $display("FAIL valid_proto: got %h want 11", o_protocol); end
        total++; if (o_frame_size !== 16'd95) begin bad++; $display("FAIL valid_size: got %0d want 95", o_frame_size); end
        total++; if (o_more_frame !== 1'b0) begin bad++; $display("FAIL valid_mf: got %b want 0", o_more_frame); end
        total++; if (o_frame_offset !== 16'd0) begin bad++; $display("FAIL valid_offset: got %h want 0", o_frame_offset); end
        total++; if (o_src_ip !== 32'hC0A8_0001) begin bad++; $display("FAIL valid_src_ip: got %h want c0a80001", o_src_ip); end
        total++; if (o_dst_ip !== 32'hC0A8_00C7) begin bad++; $display("FAIL valid_dst_ip: got %h want c0a800c7", o_dst_ip); end
        total++; if (o_dst_mac !== 48'h0200_0000_0001) begin bad++; $display("FAIL valid_dst_mac: got %h want 020000000001", o_dst_mac); end
        total++; if (o_src_mac !== 48'h0200_0000_0002) begin bad++; $display("FAIL valid_src_mac: got %h want 020000000002", o_src_mac); end
        total++; if (o_pkt_id !== 16'h0) begin bad++; $display("FAIL valid_pkt_id: got %h want 0", o_pkt_id); end
        total++; if (ecodes.size() != e0) begin bad++; $display("FAIL valid_no_err: got %0d errors want 0", ecodes.size() - e0); end
        total++;
        if (oq.size() - q0 != 24) begin
            bad++; $display("FAIL valid_words: got %0d want 24", oq.size() - q0);
        end else begin
            for (int i = 0; i < 24; i++) begin
                ow_t w;
                w = oq[q0 + i];
                total++;
                if (w.d !== pay(i) || w.s !== (i == 0) || w.e !== (i == 23) || w.x !== 1'b0 ||
                    (i == 23 && w.b !== 3'd3)) begin
                    bad++;
                    $display("FAIL valid_word%0d: got d=%h s=%b e=%b b=%0d x=%b want d=%h s=%b e=%b b=3 x=0",
                             i, w.d, w.s, w.e, w.b, w.x, pay(i), i == 0, i == 23);
                end
            end
        end
    endtask

    task automatic test_csum;
        int h0, n0, q0, e0;
        logic [2:0] c;
        h0 = hdr_n; n0 = nc_hdr_n; q0 = oq.size(); e0 = ecodes.size();
        build(32'hC0A8_00C7, 16'hB862, 24, 0);
        send_frame(fr.size(), 1'b1);
        tick(5);
        c = (ecodes.size() > e0) ? ecodes[e0] : 3'd0;
        total++; if (ecodes.size() - e0 != 1 || c !== 3'd3) begin bad++; $display("FAIL csum_err: got n=%0d code=%0d want n=1 code=3", ecodes.size() - e0, c); end
        total++; if (hdr_n != h0) begin bad++; $display("FAIL csum_hdr: got %0d want 0", hdr_n - h0); end
        total++; if (oq.size() != q0) begin bad++; $display("FAIL csum_payload: got %0d words want 0", oq.size() - q0); end
        total++; if (nc_hdr_n - n0 != 1) begin bad++; $display("FAIL csum_nocheck_hdr: got %0d want 1", nc_hdr_n - n0); end
    endtask

    task automatic test_dst;
        int h0, q0, e0;
        logic [2:0] c;
        h0 = hdr_n; q0 = oq.size(); e0 = ecodes.size();
        build(32'hC0A8_00C8, 16'hB860, 24, 0);
        send_frame(fr.size(), 1'b1);
        tick(5);
        c = (ecodes.size() > e0) ? ecodes[e0] : 3'd0;
        total++; if (ecodes.size() - e0 != 1 || c !== 3'd4) begin bad++; $display("FAIL dst_err: got n=%0d code=%0d want n=1 code=4", ecodes.size() - e0, c); end
        total++; if (hdr_n != h0 || oq.size() != q0) begin bad++; $display("FAIL dst_drop: got hdr=%0d words=%0d want 0 0", hdr_n - h0, oq.size() - q0); end
        h0 = hdr_n; q0 = oq.size(); e0 = ecodes.size();
        build(32'hFFFF_FFFF, 16'h79D1, 24, 1);
        send_frame(fr.size(), 1'b1);
        tick(5);
        total++; if (hdr_n - h0 != 1) begin bad++; $display("FAIL bcast_hdr: got %0d want 1", hdr_n - h0); end
        total++; if (o_dst_ip !== 32'hFFFF_FFFF) begin bad++; $display("FAIL bcast_dst_ip: got %h want ffffffff", o_dst_ip); end
        total++; if (oq.size() - q0 != 24 || ecodes.size() != e0) begin bad++; $display("FAIL bcast_words: got %0d errs=%0d want 24 0", oq.size() - q0, ecodes.size() - e0); end
    endtask

    task automatic test_backpressure;
        int q0, m0, mb0;
        q0 = oq.size(); m0 = mir_n; mb0 = mir_bad;
        build(32'hC0A8_00C7, 16'hB861, 24, 2);
        tog_en = 1'b1;
        send_frame(fr.size(), 1'b1);
        tick(5);
        tog_en = 1'b0;
        total++; if (mir_bad != mb0 || mir_n - m0 < 24) begin bad++; $display("FAIL bp_mirror: got bad=%0d seen=%0d want bad=0 seen>=24", mir_bad - mb0, mir_n - m0); end
        total++;
        if (oq.size() - q0 != 24) begin
            bad++; $display("FAIL bp_words: got %0d want 24", oq.size() - q0);
        end else begin
            for (int i = 0; i < 24; i++) begin
                ow_t w;
                w = oq[q0 + i];
                total++;
                if (w.d !== pay(i) || w.e !== (i == 23) || (i == 23 && w.b !== 3'd3)) begin
                    bad++;
                    $display("FAIL bp_word%0d: got d=%h e=%b b=%0d want d=%h e=%b", i, w.d, w.e, w.b, pay(i), i == 23);
                end
            end
        end
    endtask

    task automatic test_truncated;
        int h0, e0;
        logic [2:0] c;
        h0 = hdr_n; e0 = ecodes.size();
        build(32'hC0A8_00C7, 16'hB861, 0, 0);
        send_frame(7, 1'b1);
        tick(4);
        c = (ecodes.size() > e0) ? ecodes[e0] : 3'd0;
        total++; if (ecodes.size() - e0 != 1 || c !== 3'd6) begin bad++; $display("FAIL trunc_err: got n=%0d code=%0d want n=1 code=6", ecodes.size() - e0, c); end
        total++; if (hdr_n != h0) begin bad++; $display("FAIL trunc_hdr: got %0d want 0", hdr_n - h0); end
    endtask

    task automatic test_flush;
        int h0, q0, e0;
        logic [2:0] c;
        h0 = hdr_n; q0 = oq.size(); e0 = ecodes.size();
        build(32'hC0A8_00C7, 16'hB861, 24, 0);
        send_frame(14, 1'b0);
        send_frame(fr.size(), 1'b1);
        tick(5);
        c = (ecodes.size() > e0) ? ecodes[e0] : 3'd0;
        total++; if (ecodes.size() - e0 != 1 || c !== 3'd7) begin bad++; $display("FAIL flush_err: got n=%0d code=%0d want n=1 code=7", ecodes.size() - e0, c); end
        total++; if (hdr_n - h0 != 2) begin bad++; $display("FAIL flush_hdr: got %0d want 2", hdr_n - h0); end
        total++;
        if (oq.size() - q0 != 30) begin
            bad++; $display("FAIL flush_words: got %0d want 30", oq.size() - q0);
        end else begin
            for (int i = 0; i < 30; i++) begin
                ow_t w;
                logic [31:0] ed;
                logic es, ee, ex;
                w  = oq[q0 + i];
                ed = (i < 5) ? pay(i) : pay(i - 6);
                es = (i == 0) || (i == 6);
                ee = (i == 5) || (i == 29);
                ex = (i == 5);
                total++;
                if ((i != 5 && w.d !== ed) || w.s !== es || w.e !== ee || w.x !== ex ||
                    (i == 5 && w.b !== 3'd0) || (i == 29 && w.b !== 3'd3)) begin
                    bad++;
                    $display("FAIL flush_word%0d: got d=%h s=%b e=%b b=%0d x=%b want d=%h s=%b e=%b x=%b",
                             i, w.d, w.s, w.e, w.b, w.x, ed, es, ee, ex);
                end
            end
        end
    endtask

    task automatic test_rst_mid;
        int h0, q0, neop;
        q0 = oq.size();
        build(32'hC0A8_00C7, 16'hB861, 24, 0);
        send_frame(12, 1'b0);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        total++;
        if (o_eth_rdy !== 1'b0 || o_hdr_vld !== 1'b0 || o_out_vld !== 1'b0 || o_err !== 1'b0 ||
            o_protocol !== 8'd0 || o_frame_size !== 16'd0 || o_dst_ip !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_outputs: got rdy=%b hv=%b ov=%b err=%b proto=%h size=%h dip=%h want all 0",
                     o_eth_rdy, o_hdr_vld, o_out_vld, o_err, o_protocol, o_frame_size, o_dst_ip);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);
        neop = 0;
        for (int i = q0; i < oq.size(); i++) if (oq[i].e) neop++;
        total++; if (oq.size() - q0 != 3 || neop != 0) begin bad++; $display("FAIL rstmid_partial: got %0d words %0d eop want 3 words 0 eop", oq.size() - q0, neop); end
        h0 = hdr_n; q0 = oq.size();
        send_frame(fr.size(), 1'b1);
        tick(5);
        total++; if (hdr_n - h0 != 1 || o_frame_size !== 16'd95) begin bad++; $display("FAIL rstmid_next_hdr: got n=%0d size=%0d want 1 95", hdr_n - h0, o_frame_size); end
        total++;
        if (oq.size() - q0 != 24) begin
            bad++; $display("FAIL rstmid_next_words: got %0d want 24", oq.size() - q0);
        end else if (oq[q0].s !== 1'b1 || oq[q0 + 23].e !== 1'b1 || oq[q0 + 23].b !== 3'd3 ||
                     oq[q0 + 23].d !== pay(23)) begin
            bad++;
            $display("FAIL rstmid_next_framing: got sop=%b eop=%b bytes=%0d last=%h want 1 1 3 %h",
                     oq[q0].s, oq[q0 + 23].e, oq[q0 + 23].b, oq[q0 + 23].d, pay(23));
        end
    endtask

    initial begin
        rst        = 1'b1;
        i_my_ip    = 32'hC0A8_00C7;
        i_eth_data = 32'd0;
        i_eth_sop  = 1'b0;
        i_eth_eop  = 1'b0;
        i_eth_vld  = 1'b0;
        test_reset();
        test_valid();
        test_csum();
        test_dst();
        test_backpressure();
        test_truncated();
        test_flush();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
